// File: rtl/tca95xx_pkg.sv
// tca95xx_pkg: shared FSM state type, register group codes, sizing helpers and reset values
package tca95xx_pkg;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } i2c_state_t;

    localparam logic [1:0] GRP_INPUT    = 2'd0;
    localparam logic [1:0] GRP_OUTPUT   = 2'd1;
    localparam logic [1:0] GRP_POLARITY = 2'd2;
    localparam logic [1:0] GRP_CONFIG   = 2'd3;

    localparam logic [7:0] RST_OUTPUT   = 8'hFF;
    localparam logic [7:0] RST_POLARITY = 8'h00;
    localparam logic [7:0] RST_CONFIG   = 8'hFF;

    // Registers per group, rounded up to a power of two
    function automatic int group_size(input int n);
        return 1 << $clog2(n);
    endfunction

    // Width of the in-group offset field of a command byte
    function automatic int offset_bits(input int n);
        return $clog2(group_size(n));
    endfunction

endpackage

// File: rtl/i2c_target_core.sv
// i2c_target_core: I2C target bit engine with byte-level handshakes to a register file
// ports: clk, reset_n (sync, active-low); sda_in/scl_in raw pad levels; addr_sel low address bits;
//        sda_oe pulls sda low; cmd_valid/cmd/cmd_ok command byte and ACK decision;
//        wr_valid/wr_data written byte; rd_req/rd_data byte to transmit
module i2c_target_core
    import tca95xx_pkg::*;
#(
    parameter logic [4:0] ADDR_PREFIX = 5'b11101,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sda_in,
    input  logic       scl_in,
    input  logic [1:0] addr_sel,
    output logic       sda_oe,
    output logic       cmd_valid,
    output logic [7:0] cmd,
    input  logic       cmd_ok,
    output logic       wr_valid,
    output logic [7:0] wr_data,
    output logic       rd_req,
    input  logic [7:0] rd_data
);

    logic [SYNC_STAGES-1:0] sda_p, scl_p;
    logic sda_s, scl_s, sda_q, scl_q;
    logic scl_rise, scl_fall, start, stop;
    logic rw, nak, cmd_good;
    logic [3:0] cnt;
    logic [6:0] shreg;
    logic [7:0] byte_in;
    i2c_state_t state;

    assign sda_s    = sda_p[SYNC_STAGES-1];
    assign scl_s    = scl_p[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_q;
    assign scl_fall = ~scl_s & scl_q;
    assign start    = scl_s & scl_q & sda_q & ~sda_s;
    assign stop     = scl_s & scl_q & ~sda_q & sda_s;
    assign byte_in  = {shreg, sda_s};
    assign cmd      = byte_in;
    assign wr_data  = byte_in;
    assign cmd_valid = state == CMD && scl_rise && cnt == 4'd7;
    assign wr_valid  = state == WDATA && scl_rise && cnt == 4'd7;
    assign rd_req    = scl_fall && ((state == ADDR_ACK && rw) || (state == RDATA_ACK && !nak));

    // cnt counts sampled bits; 8 means the byte is complete and the ACK slot starts on the next SCL fall
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sda_p    <= '1;
            scl_p    <= '1;
            sda_q    <= 1'b1;
            scl_q    <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            rw       <= 1'b0;
            nak      <= 1'b0;
            cmd_good <= 1'b0;
            sda_oe   <= 1'b0;
        end else begin
            sda_p <= {sda_p[SYNC_STAGES-2:0], sda_in};
            scl_p <= {scl_p[SYNC_STAGES-2:0], scl_in};
            sda_q <= sda_s;
            scl_q <= scl_s;
            if (start) begin
                state  <= ADDR;
                cnt    <= '0;
                sda_oe <= 1'b0;
            end else if (stop) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
            end else begin
                unique case (state)
                    ADDR, CMD, WDATA:
                        if (scl_rise && cnt != 4'd8) begin
                            shreg <= byte_in[6:0];
                            cnt   <= cnt + 4'd1;
                            if (cnt == 4'd7 && state == ADDR) begin
                                rw <= sda_s;
                                if (byte_in[7:1] != {ADDR_PREFIX, addr_sel}) state <= IDLE;
                            end
                            if (cnt == 4'd7 && state == CMD) cmd_good <= cmd_ok;
                        end else if (scl_fall && cnt == 4'd8) begin
                            cnt    <= '0;
                            sda_oe <= state != CMD || cmd_good;
                            state  <= state == ADDR ? ADDR_ACK : state == WDATA ? WDATA_ACK : cmd_good ? CMD_ACK : IDLE;
                        end
                    ADDR_ACK, CMD_ACK, WDATA_ACK:
                        if (scl_fall) begin
                            state  <= rd_req ? RDATA : state == ADDR_ACK ? CMD : WDATA;
                            shreg  <= rd_req ? rd_data[6:0] : shreg;
                            sda_oe <= rd_req && !rd_data[7];
                        end
                    RDATA:
                        if (scl_rise && cnt != 4'd8) begin
                            cnt <= cnt + 4'd1;
                        end else if (scl_fall && cnt == 4'd8) begin
                            state  <= RDATA_ACK;
                            cnt    <= '0;
                            sda_oe <= 1'b0;
                        end else if (scl_fall && cnt != 4'd0) begin
                            shreg  <= {shreg[5:0], 1'b1};
                            sda_oe <= !shreg[6];
                        end
                    RDATA_ACK:
                        if (scl_rise) begin
                            nak <= sda_s;
                        end else if (scl_fall) begin
                            state  <= nak ? IDLE : RDATA;
                            shreg  <= rd_data[6:0];
                            sda_oe <= !nak && !rd_data[7];
                        end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/tca95xx_expander.sv
// tca95xx_expander: parametrised I2C GPIO expander with per-port change interrupt
// ports: clk, reset_n (sync, active-low); sda open-drain, scl input only; addr_sel low address bits;
//        io_port_i async pins; io_port_o/io_port_o_en pin drive; int_n active-low interrupt
module tca95xx_expander
    import tca95xx_pkg::*;
#(
    parameter int         NUM_PORTS   = 2,
    parameter logic [4:0] ADDR_PREFIX = 5'b11101,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    inout  wire                    sda,
    inout  wire                    scl,
    input  logic [1:0]             addr_sel,
    input  logic [8*NUM_PORTS-1:0] io_port_i,
    output logic [8*NUM_PORTS-1:0] io_port_o,
    output logic [8*NUM_PORTS-1:0] io_port_o_en,
    output logic                   int_n
);

    localparam int W   = 8 * NUM_PORTS;
    localparam int GS  = group_size(NUM_PORTS);
    localparam int LGS = offset_bits(NUM_PORTS);

    logic [SYNC_STAGES-1:0][W-1:0] pin_pipe;
    logic [W-1:0] pin_s, in_v, out_r, pol_r, cfg_r, snap, rd_vec;
    logic [1:0] ptr_grp;
    logic [2:0] ptr_off, ptr_inc;
    logic [7:0] cmd, cmd_off, wr_data, rd_data;
    logic cmd_valid, cmd_ok, wr_valid, rd_req, sda_oe;

    assign sda          = sda_oe ? 1'b0 : 1'bz;
    assign pin_s        = pin_pipe[SYNC_STAGES-1];
    assign in_v         = pin_s ^ pol_r;
    assign io_port_o    = out_r;
    assign io_port_o_en = ~cfg_r;
    assign cmd_off      = cmd & 8'(GS - 1);
    assign cmd_ok       = cmd < 8'(4 * GS) && cmd_off < 8'(NUM_PORTS);
    assign ptr_inc      = ptr_off == 3'(NUM_PORTS - 1) ? 3'd0 : ptr_off + 3'd1;
    assign rd_vec       = ptr_grp == GRP_INPUT ? in_v : ptr_grp == GRP_OUTPUT ? out_r : ptr_grp == GRP_POLARITY ? pol_r : cfg_r;

    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            if (ptr_off == 3'(p)) rd_data = rd_vec[8*p +: 8];
    end

    // Pin synchroniser runs through reset so snapshots load real pin levels
    always_ff @(posedge clk) pin_pipe <= {pin_pipe[SYNC_STAGES-2:0], io_port_i};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_r   <= {NUM_PORTS{RST_OUTPUT}};
            pol_r   <= {NUM_PORTS{RST_POLARITY}};
            cfg_r   <= {NUM_PORTS{RST_CONFIG}};
            snap    <= pin_s;
            ptr_grp <= GRP_INPUT;
            ptr_off <= '0;
            int_n   <= 1'b1;
        end else begin
            int_n <= ~|((pin_s ^ snap) & cfg_r);
            if (cmd_valid && cmd_ok) begin
                ptr_grp <= cmd[LGS +: 2];
                ptr_off <= cmd_off[2:0];
            end
            if (wr_valid || rd_req) ptr_off <= ptr_inc;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (ptr_off == 3'(p)) begin
                    if (wr_valid && ptr_grp == GRP_OUTPUT) out_r[8*p +: 8] <= wr_data;
                    if (wr_valid && ptr_grp == GRP_POLARITY) pol_r[8*p +: 8] <= wr_data;
                    if (wr_valid && ptr_grp == GRP_CONFIG) cfg_r[8*p +: 8] <= wr_data;
                    // Snapshot takes the pre-change value if a pin moves on this same cycle
                    if (rd_req && ptr_grp == GRP_INPUT) snap[8*p +: 8] <= pin_s[8*p +: 8];
                end
            end
        end
    end

    i2c_target_core #(
        .ADDR_PREFIX(ADDR_PREFIX),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_core (
        .clk(clk),
        .reset_n(reset_n),
        .sda_in(sda),
        .scl_in(scl),
        .addr_sel(addr_sel),
        .sda_oe(sda_oe),
        .cmd_valid(cmd_valid),
        .cmd(cmd),
        .cmd_ok(cmd_ok),
        .wr_valid(wr_valid),
        .wr_data(wr_data),
        .rd_req(rd_req),
        .rd_data(rd_data)
    );

endmodule

// File: tb/tb_tca95xx_expander.sv
// tb_tca95xx_expander: directed I2C bench for a 2-port expander at 0x74 and a 3-port one at 0x77
module tb_tca95xx_expander;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic m_sda = 1'b1;
    logic m_scl = 1'b1;
    wire sda, scl;
    logic [15:0] io_a = '0;
    logic [15:0] a_o, a_en;
    logic a_int;
    logic [23:0] io_b = '0;
    logic [23:0] b_o, b_en;
    logic b_int;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pullup (sda);
    assign sda = m_sda ? 1'bz : 1'b0;
    assign scl = m_scl;

    tca95xx_expander #(.NUM_PORTS(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .sda(sda), .scl(scl), .addr_sel(2'b00),
        .io_port_i(io_a), .io_port_o(a_o), .io_port_o_en(a_en), .int_n(a_int)
    );

    tca95xx_expander #(.NUM_PORTS(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .sda(sda), .scl(scl), .addr_sel(2'b11),
        .io_port_i(io_b), .io_port_o(b_o), .io_port_o_en(b_en), .int_n(b_int)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic qw;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start;
        m_sda = 1'b1; qw;
        m_scl = 1'b1; qw;
        m_sda = 1'b0; qw;
        m_scl = 1'b0; qw;
    endtask

    task automatic i2c_stop;
        m_sda = 1'b0; qw;
        m_scl = 1'b1; qw;
        m_sda = 1'b1; qw;
    endtask

    task automatic bit_w(input logic b);
        m_sda = b; qw;
        m_scl = 1'b1; qw; qw;
        m_scl = 1'b0; qw;
    endtask

    task automatic bit_r(output logic b);
        m_sda = 1'b1; qw;
        m_scl = 1'b1; qw;
        b = sda; qw;
        m_scl = 1'b0; qw;
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) bit_w(d[i]);
        bit_r(b);
        ack = !b;
    endtask

    task automatic rbyte(input logic last, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_r(b);
            d[i] = b;
        end
        bit_w(last);
    endtask

    initial begin
        logic ack;
        logic [7:0] d;
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b1;
        qw;
        chk("rst_a_o", 32'(a_o), 32'hFFFF);
        chk("rst_a_en", 32'(a_en), 32'h0);
        chk("rst_a_int", 32'(a_int), 32'h1);
        chk("rst_b_o", 32'(b_o), 32'hFFFFFF);

        // read CONFIG via cmd 0x06
        i2c_start; wbyte(8'hE8, ack); chk("cfg_rd_addr_ack", 32'(ack), 32'h1);
        wbyte(8'h06, ack); chk("cfg_rd_cmd_ack", 32'(ack), 32'h1);
        i2c_start; wbyte(8'hE9, ack); chk("cfg_rd_raddr_ack", 32'(ack), 32'h1);
        rbyte(1'b0, d); chk("cfg_rd_b0", 32'(d), 32'hFF);
        rbyte(1'b1, d); chk("cfg_rd_b1", 32'(d), 32'hFF);
        i2c_stop;

        // OUTPUT writes with wrap
        i2c_start; wbyte(8'hE8, ack); wbyte(8'h02, ack);
        wbyte(8'hA5, ack); wbyte(8'h3C, ack);
        chk("out_two_bytes", 32'(a_o), 32'h3CA5);
        wbyte(8'h11, ack); chk("out_wrap_ack", 32'(ack), 32'h1);
        i2c_stop;
        chk("out_wrap", 32'(a_o), 32'h3C11);
        i2c_start; wbyte(8'hE8, ack); wbyte(8'h06, ack); wbyte(8'h00, ack); i2c_stop;
        chk("cfg_port0_en", 32'(a_en), 32'h00FF);

        // polarity on inputs
        i2c_start; wbyte(8'hE8, ack); wbyte(8'h04, ack); wbyte(8'h0F, ack); i2c_stop;
        io_a = 16'h00F0;
        i2c_start; wbyte(8'hE8, ack); wbyte(8'h00, ack);
        i2c_start; wbyte(8'hE9, ack);
        rbyte(1'b0, d); chk("pol_in_p0", 32'(d), 32'hFF);
        rbyte(1'b1, d); chk("pol_in_p1", 32'(d), 32'h00);
        i2c_stop;
        chk("masked_int", 32'(a_int), 32'h1);

        // interrupt on pin 9
        io_a[9] = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("int_not_yet", 32'(a_int), 32'h1);
        @(posedge clk);
        #1 chk("int_asserted", 32'(a_int), 32'h0);
        i2c_start; wbyte(8'hE8, ack); wbyte(8'h01, ack);
        i2c_start; wbyte(8'hE9, ack);
        rbyte(1'b1, d); chk("int_port1_rd", 32'(d), 32'h02);
        i2c_stop;
        chk("int_cleared", 32'(a_int), 32'h1);
        io_a[9] = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("int_reassert", 32'(a_int), 32'h0);
        io_a[9] = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("int_back_to_snap", 32'(a_int), 32'h1);

        // NACK cases
        i2c_start; wbyte(8'hEA, ack); chk("wrong_addr_nack", 32'(ack), 32'h0); i2c_stop;
        chk("wrong_addr_no_change", 32'(a_o), 32'h3C11);
        i2c_start; wbyte(8'hE8, ack); wbyte(8'h08, ack); chk("bad_cmd_nack", 32'(ack), 32'h0); i2c_stop;

        // three-port instance: wrap from offset 2 to 0, offset 3 rejected
        i2c_start; wbyte(8'hEE, ack); chk("b_addr_ack", 32'(ack), 32'h1);
        wbyte(8'h06, ack); wbyte(8'h12, ack); wbyte(8'h34, ack); wbyte(8'h56, ack);
        i2c_stop;
        chk("b_out_wrap", 32'(b_o), 32'h125634);
        i2c_start; wbyte(8'hEE, ack); wbyte(8'h07, ack); chk("b_cmd7_nack", 32'(ack), 32'h0); i2c_stop;

        // repeated START after 4 data bits
        i2c_start; wbyte(8'hEE, ack); wbyte(8'h04, ack);
        bit_w(1'b1); bit_w(1'b0); bit_w(1'b1); bit_w(1'b0);
        i2c_start; i2c_stop;
        chk("partial_no_commit", 32'(b_o), 32'h125634);
        chk("b_int_idle", 32'(b_int), 32'h1);

        // reset during address ACK
        i2c_start;
        for (int i = 7; i >= 0; i--) bit_w(d[0] ^ d[0] ^ ((8'hE8 >> i) & 8'h01) != 8'h00);
        m_sda = 1'b1;
        #1 chk("ack_driven", 32'(sda), 32'h0);
        reset_n = 1'b0;
        @(posedge clk);
        #1 chk("reset_release_sda", 32'(sda), 32'h1);
        chk("reset_out", 32'(a_o), 32'hFFFF);
        m_scl = 1'b1;
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b1;
        qw;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
